dbus_dma: RTL and testbench

DBUS_DMA -- requirements
Module: dbus_dma

---
 rtl/dbus_pkg.sv | 14 +
 rtl/dbus_dma_if.sv | 15 +
 rtl/dbus_dma.sv | 80 ++++++++
 tb/tb_dbus_dma.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/dbus_pkg.sv
// Shared data-bus constants and the DMA state encoding.
package dbus_pkg;

   localparam int DW = 16;
   localparam int AW = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage

// File: rtl/dbus_dma_if.sv
// Data-bus bundle: one master drives address, write data and write enable.
// Bus timing: no valid/ready; a write commits on the edge while we=1, and dout
// returns the word at addr exactly one cycle after addr is presented.
interface dbus_dma_if;
   import dbus_pkg::*;

   logic [AW-1:0] addr;
   logic [DW-1:0] din;
   logic          we;
   logic [DW-1:0] dout;

   modport master (output addr, output din, output we, input dout);
   modport slave  (input addr, input din, input we, output dout);

endinterface

// File: rtl/dbus_dma.sv
// Block-copy DMA: alternates one read and one write per word over a single data bus.
// The write cycle forwards the read data combinationally from the previous read.
module dbus_dma
   import dbus_pkg::*;
#(
   parameter int LEN_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [AW-1:0]    src,
   input  logic [AW-1:0]    dst,
   input  logic [LEN_W-1:0] len,
   output logic             busy,
   output logic             done,
   output logic [AW-1:0]    m_addr,
   output logic [DW-1:0]    m_din,
   output logic             m_we,
   input  logic [DW-1:0]    m_dout,
   output state_t           dbg_state
);

   state_t           state, state_n;
   logic [AW-1:0]    src_q, dst_q;
   logic [LEN_W-1:0] len_q, idx_q, idx_inc;

   assign idx_inc   = idx_q + LEN_W'(1);
   assign dbg_state = state;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         src_q <= '0;
         dst_q <= '0;
         len_q <= '0;
         idx_q <= '0;
      end else begin
         state <= state_n;
         // Parameters are only captured in IDLE, so a start during a copy is inert.
         if (state == IDLE && start && len != '0) begin
            src_q <= src;
            dst_q <= dst;
            len_q <= len;
            idx_q <= '0;
         end else if (state == WR) begin
            idx_q <= idx_inc;
         end
      end
   end

   always_comb begin
      state_n = state;
      m_addr  = '0;
      m_din   = '0;
      m_we    = 1'b0;
      busy    = 1'b1;
      done    = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) state_n = (len != '0) ? RD : DONE;
         end
         RD: begin
            m_addr  = src_q + AW'(idx_q);
            state_n = WR;
         end
         WR: begin
            m_addr  = dst_q + AW'(idx_q);
            m_we    = 1'b1;
            m_din   = m_dout;
            state_n = (idx_inc < len_q) ? RD : DONE;
         end
         DONE: begin
            done    = 1'b1;
            state_n = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_dbus_dma.sv
// Directed bench for dbus_dma: RAM model on the bus, write/read scoreboards, cycle checks.
module tb_dbus_dma;
   import dbus_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [15:0] src = '0;
   logic [15:0] dst = '0;
   logic [7:0]  len = '0;
   logic        busy, done;
   state_t      dbg_state;

   dbus_dma_if bus ();

   dbus_dma #(.LEN_W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .src       (src),
      .dst       (dst),
      .len       (len),
      .busy      (busy),
      .done      (done),
      .m_addr    (bus.addr),
      .m_din     (bus.din),
      .m_we      (bus.we),
      .m_dout    (bus.dout),
      .dbg_state (dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   // RAM model: one-cycle read latency, write on the edge
   logic [15:0] mem [0:65535];
   always @(posedge clk) begin
      bus.dout <= mem[bus.addr];
      if (bus.we) mem[bus.addr] <= bus.din;
   end

   // scoreboard
   logic [31:0] exp_q[$];
   logic [15:0] rd_q[$];
   int n_vec  = 0;
   int n_fail = 0;
   bit mon_en = 1'b0;
   logic prev_we = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         if (bus.we) begin
            check("we_consecutive", {31'b0, prev_we}, 32'd0);
            if (exp_q.size() == 0) begin
               n_vec++;
               n_fail++;
               $display("FAIL unexpected_write: got addr %h data %h, expected no write", bus.addr, bus.din);
            end else begin
               check("write", {bus.addr, bus.din}, exp_q.pop_front());
            end
         end
         if (dbg_state == RD) begin
            if (rd_q.size() == 0) begin
               n_vec++;
               n_fail++;
               $display("FAIL unexpected_read: got addr %h, expected no read", bus.addr);
            end else begin
               check("read_addr", {16'h0, bus.addr}, {16'h0, rd_q.pop_front()});
            end
         end
         prev_we = bus.we;
      end
   end

   // driver: inj_kind 1 = second start with a different src, 2 = reset pulse
   task automatic run_copy(input logic [15:0] s, input logic [15:0] d, input logic [7:0] l,
                           input int exp_done_cyc, input int inj_cyc, input int inj_kind,
                           input int exp_busy);
      int done_cyc = 0;
      int done_cnt = 0;
      int busy_cnt = 0;
      int limit    = 2 * int'(l) + 4;
      @(negedge clk);
      src   = s;
      dst   = d;
      len   = l;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int c = 1; c <= limit; c++) begin
         @(negedge clk);
         if (busy) busy_cnt++;
         if (done) begin
            done_cnt++;
            if (done_cyc == 0) done_cyc = c;
         end
         if (inj_kind == 2 && c == inj_cyc + 1) begin
            check("reset_idle_bus", {bus.addr, bus.din}, 32'd0);
            check("reset_idle_ctl", {29'd0, bus.we, busy, done}, 32'd0);
         end
         if (c == inj_cyc && inj_kind == 1) begin
            start = 1'b1;
            src   = 16'h0500;
         end else if (c == inj_cyc && inj_kind == 2) begin
            rst = 1'b1;
         end else begin
            start = 1'b0;
            rst   = 1'b0;
         end
      end
      check("done_cycle",  done_cyc, exp_done_cyc);
      check("done_pulses", done_cnt, (exp_done_cyc != 0) ? 1 : 0);
      check("busy_cycles", busy_cnt, exp_busy);
      check("pending_writes", exp_q.size(), 0);
      check("pending_reads",  rd_q.size(), 0);
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("rst_bus", {bus.addr, bus.din}, 32'd0);
      check("rst_ctl", {29'd0, bus.we, busy, done}, 32'd0);
      mon_en = 1'b1;

      // plain copy of three words
      mem[16'h0010] = 16'hA1A1;
      mem[16'h0011] = 16'hB2B2;
      mem[16'h0012] = 16'hC3C3;
      exp_q.push_back({16'h0020, 16'hA1A1});
      exp_q.push_back({16'h0021, 16'hB2B2});
      exp_q.push_back({16'h0022, 16'hC3C3});
      rd_q.push_back(16'h0010);
      rd_q.push_back(16'h0011);
      rd_q.push_back(16'h0012);
      run_copy(16'h0010, 16'h0020, 8'd3, 7, 0, 0, 7);
      check("mem_0022", {16'h0, mem[16'h0022]}, 32'h0000C3C3);

      // zero length: straight to DONE, no bus traffic
      run_copy(16'h0010, 16'h0030, 8'd0, 1, 0, 0, 1);

      // source address wraps past 0xFFFF
      mem[16'hFFFF] = 16'h1234;
      mem[16'h0000] = 16'h5678;
      exp_q.push_back({16'h0100, 16'h1234});
      exp_q.push_back({16'h0101, 16'h5678});
      rd_q.push_back(16'hFFFF);
      rd_q.push_back(16'h0000);
      run_copy(16'hFFFF, 16'h0100, 8'd2, 5, 0, 0, 5);

      // second start during a copy must be ignored
      mem[16'h0040] = 16'h1111;
      mem[16'h0041] = 16'h2222;
      mem[16'h0042] = 16'h3333;
      mem[16'h0043] = 16'h4444;
      mem[16'h0500] = 16'hDEAD;
      mem[16'h0501] = 16'hBEEF;
      mem[16'h0502] = 16'hCAFE;
      mem[16'h0503] = 16'hF00D;
      exp_q.push_back({16'h0060, 16'h1111});
      exp_q.push_back({16'h0061, 16'h2222});
      exp_q.push_back({16'h0062, 16'h3333});
      exp_q.push_back({16'h0063, 16'h4444});
      rd_q.push_back(16'h0040);
      rd_q.push_back(16'h0041);
      rd_q.push_back(16'h0042);
      rd_q.push_back(16'h0043);
      run_copy(16'h0040, 16'h0060, 8'd4, 9, 3, 1, 9);

      // reset in cycle 4 aborts after two writes
      mem[16'h0070] = 16'h7070;
      mem[16'h0071] = 16'h7171;
      mem[16'h0072] = 16'h7272;
      mem[16'h0073] = 16'h7373;
      exp_q.push_back({16'h0080, 16'h7070});
      exp_q.push_back({16'h0081, 16'h7171});
      rd_q.push_back(16'h0070);
      rd_q.push_back(16'h0071);
      run_copy(16'h0070, 16'h0080, 8'd4, 0, 4, 2, 4);
      check("mem_0082_untouched", {16'h0, mem[16'h0082]}, 32'd0);

      // single-word copy after the abort
      exp_q.push_back({16'h0090, 16'hA1A1});
      rd_q.push_back(16'h0010);
      run_copy(16'h0010, 16'h0090, 8'd1, 3, 0, 0, 3);

      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
